ultrasonic_echo_responder: RTL and testbench

- Sensor-side model of the ultrasonic ranging interface.
- Accepts a trigger pulse from the ranging controller, waits a fixed burst delay, then drives an echo pulse whose width in clock cycles equals the programmed distance.
- Used as the far end of the echo-time measurement logic in simulation and on-board loopback, so the controller's captured echo_time can be checked against a known distance.

---
 rtl/ultrasonic_echo_responder.sv | 147 ++++++++++++++
 tb/tb_ultrasonic_echo_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_echo_responder.sv
// Sensor-side ultrasonic ranging model: qualifies a trigger pulse, waits a burst
// delay, then returns an echo whose width in cycles equals the latched distance.
module ultrasonic_echo_responder #(
    parameter int unsigned MIN_TRIG    = 10,
    parameter int unsigned BURST_DELAY = 8,
    parameter int unsigned HOLDOFF     = 16,
    parameter int unsigned DIST_W      = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [DIST_W-1:0] distance,
    output logic              echo,
    output logic              busy,
    output logic              trig_err
);

    localparam int unsigned TCNT_W = 8;
    localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_ECHO  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic              trig_q;
    logic [TCNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [DIST_W-1:0] dly_cnt_q,  dly_cnt_d;
    logic [DIST_W-1:0] echo_cnt_q, echo_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DIST_W-1:0] dist_q,     dist_d;
    logic              echo_q,     echo_d;
    logic              busy_q,     busy_d;
    logic              err_q,      err_d;
    logic              trig_rise_c;

    assign trig_rise_c = trig & ~trig_q;

    // State and counter registers; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            trig_q     <= 1'b0;
            trig_cnt_q <= '0;
            dly_cnt_q  <= '0;
            echo_cnt_q <= '0;
            hold_cnt_q <= '0;
            dist_q     <= '0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig;
            trig_cnt_q <= trig_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            echo_cnt_q <= echo_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            dist_q     <= dist_d;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        echo_cnt_d = echo_cnt_q;
        hold_cnt_d = hold_cnt_q;
        dist_d     = dist_q;
        echo_d     = echo_q;
        busy_d     = busy_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig_rise_c) begin
                    state_d    = S_TRIG;
                    busy_d     = 1'b1;
                    trig_cnt_d = TCNT_W'(1);
                end
            end
            S_TRIG: begin
                if (trig) begin
                    if (trig_cnt_q < TCNT_W'(MIN_TRIG)) begin
                        trig_cnt_d = trig_cnt_q + TCNT_W'(1);
                    end
                end else if (trig_cnt_q >= TCNT_W'(MIN_TRIG)) begin
                    state_d   = S_DELAY;
                    dist_d    = distance;
                    dly_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DELAY: begin
                if (dly_cnt_q == DIST_W'(BURST_DELAY - 1)) begin
                    if (dist_q != '0) begin
                        state_d    = S_ECHO;
                        echo_d     = 1'b1;
                        echo_cnt_d = '0;
                    end else begin
                        // Zero distance means "no object": skip straight to holdoff.
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q + DIST_W'(1);
                end
            end
            S_ECHO: begin
                if (echo_cnt_q == dist_q - DIST_W'(1)) begin
                    state_d    = S_HOLD;
                    echo_d     = 1'b0;
                    hold_cnt_d = '0;
                end else begin
                    echo_cnt_d = echo_cnt_q + DIST_W'(1);
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLDOFF - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                echo_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = err_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Self-checking bench for ultrasonic_echo_responder: event timings are compared
// against the timing rules computed directly from trigger length and distance.
module tb_ultrasonic_echo_responder;

    localparam int MIN_TRIG    = 10;
    localparam int BURST_DELAY = 8;
    localparam int HOLDOFF     = 16;
    localparam int DIST_W      = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              trig;
    logic [DIST_W-1:0] distance;
    logic              echo;
    logic              busy;
    logic              trig_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int echo_rise, echo_fall, echo_pulses;
    int busy_rise, busy_rises, busy_fall;
    int err_hi, err_cyc, inv;
    logic p_echo = 1'b0, p_busy = 1'b0, p_err = 1'b0;

    ultrasonic_echo_responder #(
        .MIN_TRIG(MIN_TRIG), .BURST_DELAY(BURST_DELAY),
        .HOLDOFF(HOLDOFF), .DIST_W(DIST_W)
    ) dut (
        .clk(clk), .reset(reset), .trig(trig), .distance(distance),
        .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    // Event monitor: cyc is the index of the posedge just passed.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #3;
        if (echo === 1'b1 && !p_echo) begin echo_pulses++; echo_rise = cyc; end
        if (echo !== 1'b1 && p_echo) echo_fall = cyc;
        if (busy === 1'b1 && !p_busy) begin busy_rises++; busy_rise = cyc; end
        if (busy !== 1'b1 && p_busy) busy_fall = cyc;
        if (trig_err === 1'b1) begin
            if (err_hi == 0) err_cyc = cyc;
            err_hi++;
        end
        if (echo === 1'b1 && busy !== 1'b1) inv++;
        if (echo === 1'b1 && trig_err === 1'b1) inv++;
        p_echo = (echo === 1'b1);
        p_busy = (busy === 1'b1);
        p_err  = (trig_err === 1'b1);
    end

    task automatic clear_mon();
        echo_rise = -1; echo_fall = -1; echo_pulses = 0;
        busy_rise = -1; busy_rises = 0; busy_fall = -1;
        err_hi = 0; err_cyc = -1; inv = 0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Trigger of len sampled-high cycles; e0 is the first edge sampling trig low.
    task automatic pulse_trig(input int len, input int d, output int e0);
        distance = DIST_W'(d);
        trig = 1'b1;
        repeat (len) @(negedge clk);
        trig = 1'b0;
        e0 = cyc + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; trig = 1'b0; distance = '0;
        repeat (5) @(negedge clk);
        n_checks++; if ({echo, busy, trig_err} !== 3'b000) $display("FAIL reset_outputs: got %b want 000", {echo, busy, trig_err}); else n_pass++;
        reset = 1'b0;
        clear_mon();
        repeat (50) @(negedge clk);
        n_checks++; if (echo_pulses !== 0) $display("FAIL idle_echo: got %0d pulses want 0", echo_pulses); else n_pass++;
        n_checks++; if (busy_rises !== 0) $display("FAIL idle_busy: got %0d rises want 0", busy_rises); else n_pass++;
        n_checks++; if (err_hi !== 0) $display("FAIL idle_err: got %0d want 0", err_hi); else n_pass++;
    endtask

    task automatic test_nominal();
        int e0;
        clear_mon();
        pulse_trig(10, 100, e0);
        wait_until(e0 + BURST_DELAY + 100 + HOLDOFF + 4);
        n_checks++; if (busy_rise !== e0 - 10) $display("FAIL nominal_busy_rise: got %0d want %0d", busy_rise, e0 - 10); else n_pass++;
        n_checks++; if (echo_rise !== e0 + 8) $display("FAIL nominal_echo_rise: got %0d want %0d", echo_rise, e0 + 8); else n_pass++;
        n_checks++; if (echo_fall - echo_rise !== 100) $display("FAIL nominal_width: got %0d want 100", echo_fall - echo_rise); else n_pass++;
        n_checks++; if (echo_pulses !== 1) $display("FAIL nominal_pulses: got %0d want 1", echo_pulses); else n_pass++;
        n_checks++; if (busy_fall !== e0 + 124) $display("FAIL nominal_busy_fall: got %0d want %0d", busy_fall, e0 + 124); else n_pass++;
        n_checks++; if (err_hi + inv !== 0) $display("FAIL nominal_err_inv: got %0d/%0d want 0/0", err_hi, inv); else n_pass++;
    endtask

    task automatic test_short_trigger();
        int e0, e1;
        clear_mon();
        pulse_trig(9, 50, e0);
        @(negedge clk);
        n_checks++; if (trig_err !== 1'b1) $display("FAIL short_err_at_e0: got %b want 1", trig_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL short_busy_at_e0: got %b want 0", busy); else n_pass++;
        pulse_trig(10, 50, e1);
        wait_until(e1 + BURST_DELAY + 50 + HOLDOFF + 4);
        n_checks++; if (err_hi !== 1 || err_cyc !== e0) $display("FAIL short_err_pulse: got %0d cycles at %0d want 1 at %0d", err_hi, err_cyc, e0); else n_pass++;
        n_checks++; if (echo_pulses !== 1) $display("FAIL short_then_ok_pulses: got %0d want 1", echo_pulses); else n_pass++;
        n_checks++; if (echo_rise !== e1 + 8) $display("FAIL short_then_ok_rise: got %0d want %0d", echo_rise, e1 + 8); else n_pass++;
        n_checks++; if (echo_fall - echo_rise !== 50) $display("FAIL short_then_ok_width: got %0d want 50", echo_fall - echo_rise); else n_pass++;
    endtask

    task automatic test_latch_ignore();
        int e0;
        clear_mon();
        pulse_trig(10, 300, e0);
        wait_until(e0 + 28);
        distance = DIST_W'(5);
        wait_until(e0 + 50); trig = 1'b1;
        wait_until(e0 + 62); trig = 1'b0;
        wait_until(e0 + 311); trig = 1'b1;
        wait_until(e0 + 321); trig = 1'b0;
        wait_until(e0 + 340);
        n_checks++; if (echo_pulses !== 1) $display("FAIL latch_pulses: got %0d want 1", echo_pulses); else n_pass++;
        n_checks++; if (echo_fall - echo_rise !== 300) $display("FAIL latch_width: got %0d want 300", echo_fall - echo_rise); else n_pass++;
        n_checks++; if (busy_rises !== 1 || busy_fall !== e0 + 324) $display("FAIL latch_busy: got %0d rises fall %0d want 1 fall %0d", busy_rises, busy_fall, e0 + 324); else n_pass++;
        n_checks++; if (err_hi + inv !== 0) $display("FAIL latch_err_inv: got %0d/%0d want 0/0", err_hi, inv); else n_pass++;
    endtask

    task automatic test_boundaries();
        int e0;
        clear_mon();
        pulse_trig(10, 0, e0);
        wait_until(e0 + 30);
        n_checks++; if (echo_pulses !== 0) $display("FAIL zero_dist_pulses: got %0d want 0", echo_pulses); else n_pass++;
        n_checks++; if (busy_fall !== e0 + 24) $display("FAIL zero_dist_busy_fall: got %0d want %0d", busy_fall, e0 + 24); else n_pass++;

        clear_mon();
        pulse_trig(10, 8191, e0);
        wait_until(e0 + BURST_DELAY + 8191 + HOLDOFF + 4);
        n_checks++; if (echo_fall - echo_rise !== 8191) $display("FAIL max_dist_width: got %0d want 8191", echo_fall - echo_rise); else n_pass++;
        n_checks++; if (busy_fall !== e0 + 8 + 8191 + 16) $display("FAIL max_dist_busy_fall: got %0d want %0d", busy_fall, e0 + 8215); else n_pass++;

        clear_mon();
        pulse_trig(40, 37, e0);
        wait_until(e0 + BURST_DELAY + 37 + HOLDOFF + 4);
        n_checks++; if (busy_rise !== e0 - 40) $display("FAIL long_trig_busy_rise: got %0d want %0d", busy_rise, e0 - 40); else n_pass++;
        n_checks++; if (echo_rise !== e0 + 8) $display("FAIL long_trig_rise: got %0d want %0d", echo_rise, e0 + 8); else n_pass++;
        n_checks++; if (echo_fall - echo_rise !== 37 || err_hi !== 0) $display("FAIL long_trig_width: got %0d err %0d want 37 err 0", echo_fall - echo_rise, err_hi); else n_pass++;
    endtask

    task automatic test_reset_mid_echo();
        int e0;
        clear_mon();
        pulse_trig(10, 500, e0);
        wait_until(e0 + BURST_DELAY + 20);
        n_checks++; if (echo !== 1'b1) $display("FAIL mid_echo_active: got %b want 1", echo); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if ({echo, busy, trig_err} !== 3'b000) $display("FAIL async_reset_clear: got %b want 000", {echo, busy, trig_err}); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (err_hi !== 0) $display("FAIL reset_no_err: got %0d want 0", err_hi); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        clear_mon();
        pulse_trig(10, 77, e0);
        wait_until(e0 + BURST_DELAY + 77 + HOLDOFF + 4);
        n_checks++; if (echo_rise !== e0 + 8) $display("FAIL post_reset_rise: got %0d want %0d", echo_rise, e0 + 8); else n_pass++;
        n_checks++; if (echo_fall - echo_rise !== 77) $display("FAIL post_reset_width: got %0d want 77", echo_fall - echo_rise); else n_pass++;
        n_checks++; if (busy_fall !== e0 + 8 + 77 + 16) $display("FAIL post_reset_busy_fall: got %0d want %0d", busy_fall, e0 + 101); else n_pass++;
    endtask

    // Random trigger lengths and distances against the timing rules.
    task automatic test_random();
        int e0, len, d, exp_fall, exp_pulses, exp_err;
        bit accept;
        for (int i = 0; i < 20; i++) begin
            len = int'($urandom_range(1, 16));
            d   = int'($urandom_range(0, 300));
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
            clear_mon();
            pulse_trig(len, d, e0);
            accept     = (len >= MIN_TRIG);
            exp_pulses = (accept && d != 0) ? 1 : 0;
            exp_err    = accept ? 0 : 1;
            exp_fall   = accept ? e0 + BURST_DELAY + d + HOLDOFF : e0;
            wait_until(exp_fall + 3);
            n_checks++; if (busy_rise !== e0 - len) $display("FAIL rnd%0d_busy_rise: got %0d want %0d", i, busy_rise, e0 - len); else n_pass++;
            n_checks++; if (busy_fall !== exp_fall) $display("FAIL rnd%0d_busy_fall: got %0d want %0d", i, busy_fall, exp_fall); else n_pass++;
            n_checks++; if (err_hi !== exp_err || echo_pulses !== exp_pulses) $display("FAIL rnd%0d_err_pulses: got %0d/%0d want %0d/%0d", i, err_hi, echo_pulses, exp_err, exp_pulses); else n_pass++;
            n_checks++; if (inv !== 0) $display("FAIL rnd%0d_invariant: got %0d want 0", i, inv); else n_pass++;
            if (exp_pulses == 1) begin
                n_checks++; if (echo_rise !== e0 + BURST_DELAY || echo_fall - echo_rise !== d) $display("FAIL rnd%0d_echo: got rise %0d width %0d want rise %0d width %0d", i, echo_rise, echo_fall - echo_rise, e0 + BURST_DELAY, d); else n_pass++;
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_nominal();
        test_short_trigger();
        test_latch_ignore();
        test_boundaries();
        test_reset_mid_echo();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
